clock_divider_prog: RTL and testbench

- Programmable integer clock divider; next generation of the team's clock_divider block.
- Generalised to any divisor N >= 2 at WIDTH bits, with near-50% duty for odd N.
- Divisor is loaded at run time through a shadow register and applied only at a period boundary, so the output never glitches.
- Adds a run enable that parks the output low at the end of a period, plus a tick strobe for synchronous consumers in the clk_in domain.

---
 rtl/clock_divider_prog_if.sv | 31 +++
 rtl/clock_divider_prog.sv | 90 +++++++++
 tb/tb_clock_divider_prog.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/clock_divider_prog_if.sv
// ============================================================================
// Module      : clock_divider_prog_if
// Description : Control/status bundle for the programmable clock divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface clock_divider_prog_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] div_in;
    logic             div_load;
    logic             pending;
    logic             div_ack;
    logic [WIDTH-1:0] active_div;
    logic             tick;
    logic             clk_out;

    modport master (
        output en, div_in, div_load,
        input  pending, div_ack, active_div, tick, clk_out
    );

    modport slave (
        input  en, div_in, div_load,
        output pending, div_ack, active_div, tick, clk_out
    );
endinterface

`default_nettype wire

// File: rtl/clock_divider_prog.sv
// ============================================================================
// Module      : clock_divider_prog
// Description : Programmable integer clock divider, glitch-free divisor swap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_divider_prog #(
    parameter int WIDTH     = 8,
    parameter int RESET_DIV = 2
) (
    input  wire logic             clk_in,
    input  wire logic             rst,
    clock_divider_prog_if.slave   bus
);
    localparam logic [WIDTH-1:0] C_RESET_DIV = RESET_DIV[WIDTH-1:0];
    localparam logic [WIDTH-1:0] C_ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_TWO       = WIDTH'(2);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] active_div;
    logic             clk_r;
    logic             tick;
    logic             pending;
    logic             div_ack;

    logic             bypass;
    logic             idle;
    logic             last;
    logic             boundary;
    logic             apply;
    logic [WIDTH:0]   high_len;

    assign bypass   = (active_div < C_TWO);
    assign idle     = (cnt == '0) && !bus.en;
    assign last     = (cnt == (active_div - C_ONE));
    assign boundary = bypass || idle || last;
    assign apply    = boundary && pending;
    // Extra bit keeps ceil(N/2) exact when N = 2^WIDTH-1.
    assign high_len = ({1'b0, active_div} + (WIDTH+1)'(1)) >> 1;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            clk_r <= 1'b0;
            tick  <= 1'b0;
        end else if (bypass) begin
            cnt   <= '0;
            clk_r <= 1'b0;
            tick  <= 1'b0;
        end else if (idle) begin
            tick  <= 1'b0;
        end else begin
            clk_r <= ({1'b0, cnt} < high_len);
            cnt   <= last ? '0 : cnt + C_ONE;
            tick  <= last;
        end
    end

    // A load coinciding with an apply lands in the shadow after the old value moves out.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            shadow     <= C_RESET_DIV;
            active_div <= C_RESET_DIV;
            pending    <= 1'b0;
            div_ack    <= 1'b0;
        end else begin
            div_ack <= apply;
            if (apply) begin
                active_div <= shadow;
            end
            if (bus.div_load) begin
                shadow  <= bus.div_in;
                pending <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

    assign bus.clk_out    = bypass ? clk_in : clk_r;
    assign bus.tick       = tick;
    assign bus.pending    = pending;
    assign bus.div_ack    = div_ack;
    assign bus.active_div = active_div;

endmodule

`default_nettype wire

// File: tb/tb_clock_divider_prog.sv
// ============================================================================
// Module      : tb_clock_divider_prog
// Description : Directed self-checking bench for clock_divider_prog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_divider_prog;
    logic clk_in;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    clock_divider_prog_if #(.WIDTH(8)) bus ();

    clock_divider_prog #(.WIDTH(8), .RESET_DIV(2)) u_dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic wait_ack(input string tag, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (bus.div_ack !== 1'b1 && n < 600);
        check(tag, 32'(bus.div_ack), 32'd1);
    endtask

    task automatic wait_rise(input string tag);
        int guard = 0;
        while (bus.clk_out !== 1'b0 && guard < 600) begin step(1); guard++; end
        while (bus.clk_out !== 1'b1 && guard < 600) begin step(1); guard++; end
        check(tag, 32'(guard < 600), 32'd1);
    endtask

    task automatic measure(input string tag, output int hi, output int lo);
        int guard = 0;
        hi = 0;
        lo = 0;
        while (bus.clk_out !== 1'b0 && guard < 600) begin step(1); guard++; end
        while (bus.clk_out !== 1'b1 && guard < 600) begin step(1); guard++; end
        while (bus.clk_out === 1'b1 && guard < 600) begin hi++; step(1); guard++; end
        while (bus.clk_out === 1'b0 && guard < 600) begin lo++; step(1); guard++; end
        check(tag, 32'(guard < 600), 32'd1);
    endtask

    task automatic load(input logic [7:0] v);
        bus.div_in   = v;
        bus.div_load = 1'b1;
        step(1);
        bus.div_load = 1'b0;
    endtask

    initial begin
        int hi, lo, n, acc, tacc;
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.div_in   = '0;
        bus.div_load = 1'b0;
        step(2);
        check("rst_clk_out", 32'(bus.clk_out), 0);
        check("rst_active", 32'(bus.active_div), 2);
        check("rst_pending", 32'(bus.pending), 0);
        check("rst_ack", 32'(bus.div_ack), 0);
        check("rst_tick", 32'(bus.tick), 0);

        // N=2 straight out of reset: toggles every edge, tick before each rise
        rst    = 1'b0;
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("n2_clk_out", 32'(bus.clk_out), 32'((i % 2) == 0));
            check("n2_tick", 32'(bus.tick), 32'((i % 2) == 1));
        end

        // N=4, then switch to 5 while running
        load(8'd4);
        wait_ack("n4_ack", n);
        check("n4_active", 32'(bus.active_div), 4);
        measure("n4_meas", hi, lo);
        check("n4_hi", 32'(hi), 2);
        check("n4_lo", 32'(lo), 2);
        load(8'd5);
        check("n5_pending", 32'(bus.pending), 1);
        wait_ack("n5_ack", n);
        check("n5_ack_tick", 32'(bus.tick), 1);
        check("n5_ack_clk_low", 32'(bus.clk_out), 0);
        check("n5_ack_pending", 32'(bus.pending), 0);
        measure("n5_meas", hi, lo);
        check("n5_hi", 32'(hi), 3);
        check("n5_lo", 32'(lo), 2);

        // N=6: drop en right after the rise; period completes then parks low
        load(8'd6);
        wait_ack("n6_ack", n);
        wait_rise("n6_rise");
        bus.en = 1'b0;
        hi = 1;
        step(1);
        while (bus.clk_out === 1'b1 && hi < 20) begin hi++; step(1); end
        check("n6_drop_hi", 32'(hi), 3);
        acc  = 0;
        tacc = 0;
        for (int i = 0; i < 12; i++) begin
            acc  += int'(bus.clk_out);
            tacc += int'(bus.tick);
            step(1);
        end
        check("n6_idle_high_samples", 32'(acc), 0);
        check("n6_idle_ticks", 32'(tacc), 1);
        bus.en = 1'b1;
        step(1);
        check("n6_restart", 32'(bus.clk_out), 1);
        measure("n6_meas", hi, lo);
        check("n6_hi", 32'(hi), 3);
        check("n6_lo", 32'(lo), 3);

        // N=8: three loads in one period, only the last survives
        load(8'd8);
        wait_ack("n8_ack", n);
        wait_rise("n8_rise");
        bus.div_load = 1'b1;
        bus.div_in = 8'd3; step(1);
        bus.div_in = 8'd7; step(1);
        bus.div_in = 8'd9; step(1);
        bus.div_load = 1'b0;
        wait_ack("n9_ack", n);
        check("n9_ack_delay", 32'(n), 4);
        check("n9_active", 32'(bus.active_div), 9);
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            acc += int'(bus.div_ack);
        end
        check("n9_single_ack", 32'(acc), 0);
        // cnt is now 8: load on the boundary edge defers to the next boundary
        load(8'd4);
        check("bnd_no_ack", 32'(bus.div_ack), 0);
        check("bnd_pending", 32'(bus.pending), 1);
        check("bnd_tick", 32'(bus.tick), 1);
        check("bnd_active", 32'(bus.active_div), 9);
        wait_ack("bnd_ack", n);
        check("bnd_ack_delay", 32'(n), 9);
        check("bnd_active_new", 32'(bus.active_div), 4);

        // Bypass: load 0 while idle
        bus.en = 1'b0;
        step(8);
        check("idle_low", 32'(bus.clk_out), 0);
        load(8'd0);
        check("byp_pending", 32'(bus.pending), 1);
        check("byp_no_ack", 32'(bus.div_ack), 0);
        step(1);
        check("byp_ack", 32'(bus.div_ack), 1);
        check("byp_active", 32'(bus.active_div), 0);
        check("byp_clk_hi", 32'(bus.clk_out), 1);
        @(negedge clk_in);
        #1;
        check("byp_clk_lo", 32'(bus.clk_out), 0);
        step(1);
        bus.en = 1'b1;
        tacc = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            tacc += int'(bus.tick);
        end
        check("byp_tick", 32'(tacc), 0);
        load(8'd10);
        step(1);
        check("n10_ack", 32'(bus.div_ack), 1);
        check("n10_active", 32'(bus.active_div), 10);
        measure("n10_meas", hi, lo);
        check("n10_hi", 32'(hi), 5);
        check("n10_lo", 32'(lo), 5);

        // Largest divisor
        load(8'd255);
        wait_ack("n255_ack", n);
        check("n255_active", 32'(bus.active_div), 255);
        measure("n255_meas", hi, lo);
        check("n255_hi", 32'(hi), 128);
        check("n255_lo", 32'(lo), 127);

        // Async reset mid-high at N=9 discards a pending load
        load(8'd9);
        wait_ack("r9_ack", n);
        wait_rise("r9_rise");
        step(1);
        load(8'd5);
        check("r9_pending", 32'(bus.pending), 1);
        check("r9_high", 32'(bus.clk_out), 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_clk_out", 32'(bus.clk_out), 0);
        check("arst_active", 32'(bus.active_div), 2);
        check("arst_pending", 32'(bus.pending), 0);
        step(1);
        rst = 1'b0;
        step(1);
        check("post_rst_hi", 32'(bus.clk_out), 1);
        step(1);
        check("post_rst_lo", 32'(bus.clk_out), 0);
        check("post_rst_tick", 32'(bus.tick), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
